// File: rtl/mem_dp_ram.sv
// rtl/mem_dp_ram.sv - dual-port word RAM (A: r/w with byte enables, B: read-only) with clear engine
// Optional per-byte even parity storage and checking: define MEM_DP_RAM_PARITY_EN.
`timescale 1ns/1ps
module mem_dp_ram #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 4,
  parameter int                RD_LAT     = 1,
  parameter int                WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  input  logic              perr_inject,
  output logic              a_perr,
  output logic              b_perr
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic { S_CLEAR, S_READY } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr, w_a_rd, w_b_rd;
  logic [DATA_W-1:0] w_a_word, w_b_word;
  logic              w_a_err, w_b_err;

  assign ready  = (r_state == S_READY);
  assign w_wr   = ready & a_en & a_we;
  assign w_a_rd = ready & a_en & ~a_we;
  assign w_b_rd = ready & b_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      S_CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (clr_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

`ifdef MEM_DP_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_wpar, w_b_par;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
    for (int i = 0; i < NB; i++) byte_par[i] = ^d[8*i +: 8];
  endfunction

  assign w_wpar = byte_par(a_wdata) ^ {NB{perr_inject}};
`else
  logic w_unused_inject;
  assign w_unused_inject = perr_inject;
`endif

  // Array has no reset; the clear engine owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_ptr] <= INIT_VALUE;
`ifdef MEM_DP_RAM_PARITY_EN
      r_par[r_clr_ptr] <= byte_par(INIT_VALUE);
`endif
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) begin
          r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
`ifdef MEM_DP_RAM_PARITY_EN
          r_par[a_addr][i] <= w_wpar[i];
`endif
        end
      end
    end
  end

  always_comb begin
    w_a_word = r_mem[a_addr];
    w_b_word = r_mem[b_addr];
`ifdef MEM_DP_RAM_PARITY_EN
    w_b_par  = r_par[b_addr];
`endif
    // Write-first: forward the bytes being written this cycle onto port B.
    if (WRITE_MODE == 1 && w_wr && a_addr == b_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) begin
          w_b_word[8*i +: 8] = a_wdata[8*i +: 8];
`ifdef MEM_DP_RAM_PARITY_EN
          w_b_par[i] = w_wpar[i];
`endif
        end
      end
    end
  end

`ifdef MEM_DP_RAM_PARITY_EN
  assign w_a_err = |(r_par[a_addr] ^ byte_par(w_a_word));
  assign w_b_err = |(w_b_par ^ byte_par(w_b_word));
`else
  assign w_a_err = 1'b0;
  assign w_b_err = 1'b0;
`endif

  logic              r_a_v1, r_b_v1, r_a_e1, r_b_e1;
  logic [DATA_W-1:0] r_a_d1, r_b_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_e1 <= 1'b0;
      r_b_e1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      r_a_e1 <= w_a_rd & w_a_err;
      r_b_e1 <= w_b_rd & w_b_err;
      if (w_a_rd) r_a_d1 <= w_a_word;
      if (w_b_rd) r_b_d1 <= w_b_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_a_v2, r_b_v2, r_a_e2, r_b_e2;
    logic [DATA_W-1:0] r_a_d2, r_b_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_v2 <= 1'b0;
        r_b_v2 <= 1'b0;
        r_a_e2 <= 1'b0;
        r_b_e2 <= 1'b0;
        r_a_d2 <= '0;
        r_b_d2 <= '0;
      end else begin
        r_a_v2 <= r_a_v1;
        r_b_v2 <= r_b_v1;
        r_a_e2 <= r_a_e1;
        r_b_e2 <= r_b_e1;
        if (r_a_v1) r_a_d2 <= r_a_d1;
        if (r_b_v1) r_b_d2 <= r_b_d1;
      end
    end

    assign a_rvalid = r_a_v2;
    assign b_rvalid = r_b_v2;
    assign a_perr   = r_a_e2;
    assign b_perr   = r_b_e2;
    assign a_rdata  = r_a_d2;
    assign b_rdata  = r_b_d2;
  end else begin : g_lat1
    if (RD_LAT != 1) begin : g_bad_lat
      $error("mem_dp_ram: RD_LAT must be 1 or 2");
    end
    assign a_rvalid = r_a_v1;
    assign b_rvalid = r_b_v1;
    assign a_perr   = r_a_e1;
    assign b_perr   = r_b_e1;
    assign a_rdata  = r_a_d1;
    assign b_rdata  = r_b_d1;
  end
endmodule

// File: doc/mem_dp_ram.md
Name: mem_dp_ram

Overview:
- Parametrised dual-port word memory; successor to the single-port Memory block.
- Port A: read/write with byte enables (CPU data side). Port B: read-only (instruction fetch side).
- Adds configurable read latency, a ready handshake, hardware clear after reset or on request, and optional parity.

Parameters:
DATA_W, 32, word width; multiple of 8
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WRITE_MODE, 0, collision policy on port B: 0 = read-first (old data), 1 = write-first (new data)
INIT_VALUE, 0, word written to every address by the clear engine

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  pulse; restarts clear engine when ready=1
ready  out  1  1 = array usable; 0 while clearing
a_en  in  1  port A access request
a_we  in  1  1 = write, 0 = read (qualified by a_en)
a_addr  in  ADDR_W  port A word address
a_be  in  DATA_W/8  byte enables for writes; bit i = bits 8i+7:8i
a_wdata  in  DATA_W  write data
a_rdata  out  DATA_W  port A read data
a_rvalid  out  1  one-cycle pulse; a_rdata valid
b_en  in  1  port B read request
b_addr  in  ADDR_W  port B word address
b_rdata  out  DATA_W  port B read data
b_rvalid  out  1  one-cycle pulse; b_rdata valid
perr_inject  in  1  debug: invert stored parity on the next port A write
a_perr, b_perr  out  1  parity error, aligned with the matching rvalid

Behaviour:
- Reset (rst_n=0, asynchronous): ready=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, a_perr=b_perr=0; FSM->S_CLEAR with clr_ptr=0. Array contents are not reset.
- FSM states: S_CLEAR, S_READY.
- S_CLEAR: each cycle writes INIT_VALUE (with correct parity) to clr_ptr, then clr_ptr++. After writing DEPTH-1, go to S_READY. ready rises exactly DEPTH cycles after rst_n release.
- S_READY: ready=1. clr_req=1 -> S_CLEAR with clr_ptr=0, ready=0 the next cycle. In-flight reads still complete.
- clr_req during S_CLEAR is ignored. Reset asserted mid-clear restarts the clear from address 0.
- Requests with ready=0 are dropped: no write, no rvalid.
- Port A write (a_en&a_we): updates only bytes with a_be=1 on that clk edge; a_be=0 is a no-op write. No rvalid is produced.
- Reads (A with a_en&!a_we, or B with b_en): rvalid and rdata appear RD_LAT cycles after the request edge.
  - RD_LAT=2 adds an output register stage.
  - Back-to-back reads are fully pipelined: 1 per cycle per port.
  - rdata holds its last value when rvalid=0.
- Collision (A write and B read, same address, same cycle): WRITE_MODE=0 -> B returns pre-write word. WRITE_MODE=1 -> B returns post-write word, merged per a_be.
- A and B reading the same address are independent, with no interaction.
- Address width exactly covers DEPTH; no wrap handling needed.
- Unsupported RD_LAT: elaboration error ($error in generate).

Optional Feature:
- Macro: MEM_DP_RAM_PARITY_EN.
- Defined:
  - Each word stores one even-parity bit per byte.
  - On read, recomputed parity is compared; any byte mismatch sets a_perr/b_perr together with rvalid, cleared otherwise.
  - perr_inject=1 with a port A write stores inverted parity for all written bytes.
- Undefined: no parity storage; a_perr=b_perr=0 constantly; perr_inject ignored.

Test Plan:
- Release rst_n with ADDR_W=4 -> ready=0 for 16 cycles, 1 on cycle 16; reads of all 16 addresses on A and B return INIT_VALUE.
- A write addr 3 data 0xDEADBEEF be=1111, then A read addr 3 (RD_LAT=1) -> a_rvalid one cycle later, a_rdata=0xDEADBEEF. Repeat with RD_LAT=2 -> two cycles later.
- A write addr 3 data 0x11223344 be=0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
- Same-cycle A write 0xCAFEF00D and B read at addr 5 (old 0) -> b_rdata=0 (WRITE_MODE=0), b_rdata=0xCAFEF00D (WRITE_MODE=1).
- Assert clr_req, then issue A writes during clear -> writes dropped, ready low 16 cycles, all words INIT_VALUE afterward. Pull rst_n mid-clear -> clear restarts from 0.
- Parity defined: A write with perr_inject=1 to addr 7, then B read addr 7 -> b_perr=1 with b_rvalid. Rewrite without inject -> b_perr=0. Macro undefined -> b_perr=0 in both cases.
